// File: rtl/ysyx_24100005_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states, requester IDs
// and the timer-width helper.
package ysyx_24100005_mem_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // A disabled timeout (0) still gets a 1-bit timer so no zero-width vector exists.
    function automatic int unsigned timer_width(input int unsigned timeout);
        if (timeout == 0) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the one that was
// not granted last wins.
module ysyx_24100005_rr_arb2
    import ysyx_24100005_mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  req_id_e            last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output req_id_e            gnt_id_o
);

    always_comb begin
        gnt_id_o = REQ_IFU;
        if (req_i[REQ_IFU] && req_i[REQ_LSU]) begin
            gnt_id_o = (last_i == REQ_IFU) ? REQ_LSU : REQ_IFU;
        end else if (req_i[REQ_LSU]) begin
            gnt_id_o = REQ_LSU;
        end
        gnt_o           = '0;
        gnt_o[gnt_id_o] = |req_i;
    end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares the single data-memory port between IFU and LSU: one outstanding
// transaction, round-robin on conflict, sticky timeout flag on a stalled memory.
module ysyx_24100005_mem_arbiter
    import ysyx_24100005_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MASK_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_resp_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              timeout_err
);

    localparam int unsigned TMR_W = timer_width(TIMEOUT);

    state_e              state_q, state_d;
    req_id_e             owner_q, owner_d;
    req_id_e             last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic [NUM_REQ-1:0]  gnt;
    req_id_e             gnt_id;
    logic                accept_c;
    logic                timeout_hit_c;
    logic                owner_ready_c;

    ysyx_24100005_rr_arb2 u_rr_arb2 (
        .req_i    ({lsu_req_valid, ifu_req_valid}),
        .last_i   (last_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign accept_c      = (state_q == S_IDLE) && (|gnt);
    assign timeout_hit_c = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT));
    assign owner_ready_c = (owner_q == REQ_LSU) ? lsu_resp_ready : ifu_resp_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept_c) state_d = S_ISSUE;
            S_ISSUE: if (mem_req_ready) state_d = mem_resp_valid ? S_RESP : S_WAIT;
            S_WAIT:  if (mem_resp_valid || timeout_hit_c) state_d = S_RESP;
            S_RESP:  if (owner_ready_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; request ready is masked during reset so nothing handshakes
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ifu_req_ready = !rst && gnt[REQ_IFU];
                lsu_req_ready = !rst && gnt[REQ_LSU];
            end
            S_ISSUE: mem_req_valid = 1'b1;
            S_RESP: begin
                ifu_resp_valid = (owner_q == REQ_IFU);
                lsu_resp_valid = (owner_q == REQ_LSU);
            end
            default: ;
        endcase
    end

    // Request capture, WAIT timer and response data
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        timer_d = timer_q;
        if (accept_c) begin
            owner_d = gnt_id;
            last_d  = gnt_id;
            if (gnt_id == REQ_IFU) begin
                addr_d  = ifu_req_addr;
                wen_d   = 1'b0;
                wdata_d = '0;
                wmask_d = '0;
            end else begin
                addr_d  = lsu_req_addr;
                wen_d   = lsu_req_wen;
                wdata_d = lsu_req_wdata;
                wmask_d = lsu_req_wmask;
            end
        end
        if (state_q == S_ISSUE && mem_req_ready) begin
            timer_d = TMR_W'(1);
            if (mem_resp_valid) begin
                rdata_d = mem_resp_rdata;
            end
        end
        if (state_q == S_WAIT) begin
            if (mem_resp_valid) begin
                rdata_d = mem_resp_rdata;
            end else if (timeout_hit_c) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else if (timer_q != {TMR_W{1'b1}}) begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= REQ_IFU;
            last_q  <= REQ_LSU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign ifu_resp_rdata = rdata_q;
    assign lsu_resp_rdata = rdata_q;
    assign timeout_err    = err_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: transaction-level model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ysyx_24100005_mem_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
    logic [31:0] ifu_req_addr = '0, ifu_resp_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_wen = 1'b0, lsu_resp_valid;
    logic        lsu_resp_ready = 1'b0;
    logic [31:0] lsu_req_addr = '0, lsu_req_wdata = '0, lsu_resp_rdata;
    logic [7:0]  lsu_req_wmask = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0, timeout_err;
    logic [31:0] mem_resp_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    // Model of the single transaction in flight
    bit          m_busy, m_sent, m_done, m_owner_lsu, m_last_lsu, m_err, m_silent;
    int          m_wait;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          m_wen;
    logic [7:0]  m_wmask;

    ysyx_24100005_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MASK_W(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_sent = 0; m_done = 0; m_owner_lsu = 0; m_last_lsu = 1;
        m_err = 0; m_silent = 0; m_wait = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_wen = 0; m_wmask = '0;
    endtask

    task automatic check_outputs();
        bit exp_ifu_rdy, exp_lsu_rdy, exp_mreq, exp_ifu_rv, exp_lsu_rv;
        exp_ifu_rdy = !rst && !m_busy && ifu_req_valid && (!lsu_req_valid || m_last_lsu);
        exp_lsu_rdy = !rst && !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
        exp_mreq    = m_busy && !m_sent;
        exp_ifu_rv  = m_busy && m_done && !m_owner_lsu;
        exp_lsu_rv  = m_busy && m_done && m_owner_lsu;
        chk("ifu_req_ready", 32'(ifu_req_ready), 32'(exp_ifu_rdy));
        chk("lsu_req_ready", 32'(lsu_req_ready), 32'(exp_lsu_rdy));
        chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_mreq));
        chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(exp_ifu_rv));
        chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(exp_lsu_rv));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        if (exp_mreq) begin
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk("mem_req_wen", 32'(mem_req_wen), 32'(m_wen));
            chk("mem_req_wmask", 32'(mem_req_wmask), 32'(m_wmask));
            if (m_wen) chk("mem_req_wdata", mem_req_wdata, m_wdata);
        end
        if (exp_ifu_rv) chk("ifu_resp_rdata", ifu_resp_rdata, m_rdata);
        if (exp_lsu_rv) chk("lsu_resp_rdata", lsu_resp_rdata, m_rdata);
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_update();
        if (rst) return;
        if (!m_busy) begin
            if (ifu_req_valid || lsu_req_valid) begin
                m_owner_lsu = lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
                m_last_lsu  = m_owner_lsu;
                m_busy = 1; m_sent = 0; m_done = 0; m_wait = 0;
                m_silent = ($urandom_range(0, 9) == 0);
                if (m_owner_lsu) begin
                    m_addr = lsu_req_addr; m_wen = lsu_req_wen;
                    m_wdata = lsu_req_wdata; m_wmask = lsu_req_wmask;
                end else begin
                    m_addr = ifu_req_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
                end
            end
        end else if (!m_sent) begin
            if (mem_req_ready) begin
                m_sent = 1;
                if (mem_resp_valid) begin m_done = 1; m_rdata = mem_resp_rdata; end
            end
        end else if (!m_done) begin
            m_wait++;
            if (mem_resp_valid) begin
                m_done = 1; m_rdata = mem_resp_rdata;
            end else if (m_wait == int'(TO)) begin
                m_done = 1; m_rdata = '0; m_err = 1;
            end
        end else if (m_owner_lsu ? lsu_resp_ready : ifu_resp_ready) begin
            m_busy = 0; m_sent = 0; m_done = 0;
        end
    endtask

    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; lsu_req_valid = 0; lsu_req_wen = 0;
        ifu_resp_ready = 0; lsu_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
    endtask

    task automatic mem_auto();
        mem_req_ready  = 1'($urandom_range(0, 1));
        mem_resp_rdata = $urandom;
        if (m_busy && !m_sent)
            mem_resp_valid = mem_req_ready && !m_silent && ($urandom_range(0, 3) == 0);
        else if (m_busy && !m_done)
            mem_resp_valid = !m_silent && ($urandom_range(0, 2) == 0);
        else
            mem_resp_valid = ($urandom_range(0, 9) == 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
        model_reset();
        settle();
        chk("rst_mem_req_addr", mem_req_addr, 32'h0);
        chk("rst_rdata", ifu_resp_rdata, 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 0; mem_resp_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        ifu_req_valid = 0; lsu_req_valid = 0; ifu_resp_ready = 1; lsu_resp_ready = 1;
        while (m_busy && n < 40) begin
            mem_auto(); settle(); advance(); n++;
        end
        n_chk++;
        if (m_busy) begin
            n_fail++;
            $display("FAIL drain: transaction still open after %0d cycles", n);
        end
        idle_inputs();
    endtask

    initial begin
        int grants[$];
        int n;
        model_reset();
        @(negedge clk);
        do_reset();

        // Tie after reset: IFU first, then strict alternation
        n = 0;
        while (grants.size() < 4 && n < 40) begin
            ifu_req_valid = 1; lsu_req_valid = 1; ifu_req_addr = $urandom; lsu_req_addr = $urandom;
            lsu_req_wen = 0; ifu_resp_ready = 1; lsu_resp_ready = 1;
            mem_req_ready = 1; mem_resp_valid = m_busy && !m_sent; mem_resp_rdata = $urandom;
            settle();
            if (ifu_req_ready) grants.push_back(0);
            if (lsu_req_ready) grants.push_back(1);
            advance(); n++;
        end
        chk("alt_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("alt_grant_order", 32'(grants[i]), 32'(i % 2));
        drain();

        // IFU-only fetch, memory answers after two WAIT cycles
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
        settle(); chk("ifu_only_ready", 32'(ifu_req_ready), 32'd1); advance();
        ifu_req_valid = 0; ifu_req_addr = 32'h1234_5678; mem_req_ready = 1;
        settle();
        chk("ifu_only_addr", mem_req_addr, 32'h8000_0000);
        chk("ifu_only_wen", 32'(mem_req_wen), 32'd0);
        advance();
        mem_req_ready = 0; settle(); advance();
        mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413; settle(); advance();
        mem_resp_valid = 0; mem_resp_rdata = '0; ifu_resp_ready = 1;
        settle();
        chk("ifu_only_rvalid", 32'(ifu_resp_valid), 32'd1);
        chk("ifu_only_rdata", ifu_resp_rdata, 32'h0000_0413);
        chk("ifu_only_lsu_quiet", 32'(lsu_resp_valid), 32'd0);
        advance();
        drain();

        // LSU store with memory stalling five cycles
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1;
        lsu_req_wdata = 32'hCAFE_BABE; lsu_req_wmask = 8'h0F;
        settle(); chk("store_ready", 32'(lsu_req_ready), 32'd1); advance();
        lsu_req_valid = 0; lsu_req_addr = 32'hFFFF_FFFF; lsu_req_wdata = 32'h0; lsu_req_wmask = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("store_stall_valid", 32'(mem_req_valid), 32'd1);
            chk("store_stall_addr", mem_req_addr, 32'h8000_0100);
            chk("store_stall_wdata", mem_req_wdata, 32'hCAFE_BABE);
            chk("store_stall_wmask", 32'(mem_req_wmask), 32'h0F);
            chk("store_stall_wen", 32'(mem_req_wen), 32'd1);
            advance();
        end
        mem_req_ready = 1; settle(); advance();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0001; lsu_resp_ready = 1;
        settle(); advance();
        mem_resp_valid = 0;
        settle(); chk("store_ack", 32'(lsu_resp_valid), 32'd1); advance();
        drain();

        // LSU response held off while IFU keeps requesting
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_0200;
        settle(); advance();
        lsu_req_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h5555_AAAA;
        settle(); chk("hold_issue_ifu_rdy", 32'(ifu_req_ready), 32'd0); advance();
        mem_req_ready = 0; mem_resp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_lsu_rvalid", 32'(lsu_resp_valid), 32'd1);
            chk("hold_ifu_rdy", 32'(ifu_req_ready), 32'd0);
            advance();
        end
        lsu_resp_ready = 1;
        settle(); chk("hold_consume_ifu_rdy", 32'(ifu_req_ready), 32'd0); advance();
        settle(); chk("hold_after_ifu_rdy", 32'(ifu_req_ready), 32'd1); advance();
        drain();

        // Memory never responds: RESP after TO WAIT cycles, sticky error
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0300;
        settle(); advance();
        lsu_req_valid = 0; mem_req_ready = 1; settle(); advance();
        mem_req_ready = 0;
        n = 0;
        while (n < 50) begin
            settle();
            if (lsu_resp_valid) break;
            advance(); n++;
        end
        chk("timeout_wait_cycles", 32'(n), 32'(TO));
        chk("timeout_rdata", lsu_resp_rdata, 32'h0);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        lsu_resp_ready = 1; advance();
        lsu_resp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("timeout_err_sticky", 32'(timeout_err), 32'd1); advance();
        end

        // Reset while waiting on memory; stale response afterwards is ignored
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0400;
        settle(); advance();
        lsu_req_valid = 0; mem_req_ready = 1; settle(); advance();
        mem_req_ready = 0; settle(); advance();
        do_reset();
        chk("rst_wait_mem_valid", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1; mem_resp_rdata = 32'h0BAD_0BAD; settle(); advance();
        mem_resp_valid = 0;
        settle(); chk("rst_wait_no_resp", 32'(lsu_resp_valid), 32'd0); advance();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) do_reset();
            ifu_req_valid  = ($urandom_range(0, 2) != 0);
            lsu_req_valid  = ($urandom_range(0, 2) != 0);
            ifu_req_addr   = $urandom;
            lsu_req_addr   = $urandom;
            lsu_req_wen    = 1'($urandom_range(0, 1));
            lsu_req_wdata  = $urandom;
            lsu_req_wmask  = 8'($urandom);
            ifu_resp_ready = ($urandom_range(0, 3) != 0);
            lsu_resp_ready = ($urandom_range(0, 3) != 0);
            mem_auto();
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
